// File: rtl/regset_arb_pkg.sv
// Shared types and default sizing for the register-set arbiter.
// State encoding is fixed here so that the top and any bench agree on it.
package regset_arb_pkg;

    localparam int unsigned N_DEFAULT  = 8;
    localparam int unsigned AW_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        RWAIT = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a last-grant pointer.
// Grants are combinational and qualified by en; the pointer moves only on a grant.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    // last1_q = 1 means requester 1 won most recently, so requester 0 has priority.
    logic last1_q;

    always_comb begin
        gnt0 = en && req0 && (!req1 || last1_q);
        gnt1 = en && req1 && (!req0 || !last1_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last1_q <= 1'b1;
        end else if (gnt0) begin
            last1_q <= 1'b0;
        end else if (gnt1) begin
            last1_q <= 1'b1;
        end
    end

endmodule

// File: rtl/regset_arbiter.sv
// Arbitrates two requesters onto a single register-set command port.
// Optional macro REGSET_ARB_STATS_EN adds the Conflict_cnt output.
module regset_arbiter
    import regset_arb_pkg::*;
#(
    parameter int unsigned N  = N_DEFAULT,
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Req0,
    input  logic          Req1,
    input  logic          RW0,
    input  logic          RW1,
    input  logic [AW-1:0] Addr0,
    input  logic [AW-1:0] Addr1,
    input  logic [N-1:0]  Wdata0,
    input  logic [N-1:0]  Wdata1,
    output logic          Gnt0,
    output logic          Gnt1,
    output logic          Done0,
    output logic          Done1,
    output logic [N-1:0]  Rdata,
    output logic          RS_Enable,
    output logic          RS_RW,
    output logic [AW-1:0] RS_Address,
    output logic [N-1:0]  RS_Data_in,
    input  logic [N-1:0]  RS_Data_out
`ifdef REGSET_ARB_STATS_EN
    ,
    output logic [7:0]    Conflict_cnt
`endif
);

    state_t        state_q, state_d;
    logic          arb_en;
    logic          grant_any;
    logic          rw_q;
    logic          owner_q;
    logic [AW-1:0] addr_q;
    logic [N-1:0]  wdata_q;
    logic          rd_done_q;
    logic          rd_owner_q;
    logic [N-1:0]  rdata_q;

    assign arb_en    = (state_q == IDLE) && !Reset;
    assign grant_any = Gnt0 || Gnt1;
    assign Rdata     = rdata_q;

    rr_arb2 u_rr (
        .clk   (Clk),
        .reset (Reset),
        .en    (arb_en),
        .req0  (Req0),
        .req1  (Req1),
        .gnt0  (Gnt0),
        .gnt1  (Gnt1)
    );

    // Combinational strobes are masked by Reset so an abort never leaks a command or Done.
    always_comb begin
        state_d    = state_q;
        RS_Enable  = 1'b0;
        RS_RW      = 1'b0;
        RS_Address = '0;
        RS_Data_in = '0;
        Done0      = 1'b0;
        Done1      = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                state_d = rw_q ? IDLE : RWAIT;
                if (!Reset) begin
                    RS_Enable  = 1'b1;
                    RS_RW      = rw_q;
                    RS_Address = addr_q;
                    RS_Data_in = wdata_q;
                    Done0      = rw_q && !owner_q;
                    Done1      = rw_q && owner_q;
                end
            end
            RWAIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Read completion lands in the IDLE cycle after RWAIT, never alongside a write Done.
        if (rd_done_q && !Reset) begin
            Done0 = Done0 || !rd_owner_q;
            Done1 = Done1 || rd_owner_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            rw_q       <= 1'b0;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_done_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rd_done_q  <= (state_q == RWAIT);
            rd_owner_q <= owner_q;
            if (grant_any) begin
                owner_q <= Gnt1;
                rw_q    <= Gnt1 ? RW1    : RW0;
                addr_q  <= Gnt1 ? Addr1  : Addr0;
                wdata_q <= Gnt1 ? Wdata1 : Wdata0;
            end
            if (state_q == RWAIT) begin
                rdata_q <= RS_Data_out;
            end
        end
    end

`ifdef REGSET_ARB_STATS_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Conflict_cnt <= '0;
        end else if ((state_q == IDLE) && Req0 && Req1 && (Conflict_cnt != 8'hFF)) begin
            Conflict_cnt <= Conflict_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regset_arbiter.sv
// Directed bench for regset_arbiter: a transaction-level schedule model checked every cycle,
// plus literal expectations for the reset state, latencies, grant order and reset abort.
module tb_regset_arbiter;

    localparam int MAXC = 2048;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Req0, Req1, RW0, RW1;
    logic [2:0] Addr0, Addr1;
    logic [7:0] Wdata0, Wdata1;
    logic       Gnt0, Gnt1, Done0, Done1;
    logic [7:0] Rdata;
    logic       RS_Enable, RS_RW;
    logic [2:0] RS_Address;
    logic [7:0] RS_Data_in;
    logic [7:0] RS_Data_out = 8'h00;
`ifdef REGSET_ARB_STATS_EN
    logic [7:0] Conflict_cnt;
`endif

    regset_arbiter #(.N(8), .AW(3)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Req0        (Req0),
        .Req1        (Req1),
        .RW0         (RW0),
        .RW1         (RW1),
        .Addr0       (Addr0),
        .Addr1       (Addr1),
        .Wdata0      (Wdata0),
        .Wdata1      (Wdata1),
        .Gnt0        (Gnt0),
        .Gnt1        (Gnt1),
        .Done0       (Done0),
        .Done1       (Done1),
        .Rdata       (Rdata),
        .RS_Enable   (RS_Enable),
        .RS_RW       (RS_RW),
        .RS_Address  (RS_Address),
        .RS_Data_in  (RS_Data_in),
        .RS_Data_out (RS_Data_out)
`ifdef REGSET_ARB_STATS_EN
        ,
        .Conflict_cnt(Conflict_cnt)
`endif
    );

    initial forever #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Register set attached to the command port: writes land at the edge, reads return a cycle later.
    logic [7:0] tb_mem [8] = '{default: 8'h00};
    always @(posedge Clk) begin
        if (RS_Enable && RS_RW) tb_mem[RS_Address] <= RS_Data_in;
        if (RS_Enable && !RS_RW) RS_Data_out <= tb_mem[RS_Address];
    end

    int passes = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Expected-event schedule, indexed by absolute cycle number.
    bit         ev_cmd [MAXC];
    bit         ev_rw  [MAXC];
    logic [2:0] ev_a   [MAXC];
    logic [7:0] ev_d   [MAXC];
    bit         ev_d0  [MAXC];
    bit         ev_d1  [MAXC];
    bit         ev_rd  [MAXC];
    logic [7:0] ev_rdv [MAXC];
    logic [7:0] ref_mem [8] = '{default: 8'h00};
    logic [7:0] m_rdata = 8'h00;
    int         next_free = 0;
    bit         last1 = 1'b1;
    int         m_conf = 0;
    bit         log_en = 1'b0;
    int         glog [$];

    initial forever begin
        bit eg0, eg1, w, rw;
        logic [2:0] a;
        logic [7:0] d;
        @(negedge Clk);
        if (Reset) begin
            chk("rst_gnt0", Gnt0, 0);
            chk("rst_gnt1", Gnt1, 0);
            chk("rst_done0", Done0, 0);
            chk("rst_done1", Done1, 0);
            chk("rst_rs_en", RS_Enable, 0);
            chk("rst_rs_rw", RS_RW, 0);
            chk("rst_rs_addr", RS_Address, 0);
            chk("rst_rs_din", RS_Data_in, 0);
            for (int k = cyc; k < cyc + 5 && k < MAXC; k++) begin
                ev_cmd[k] = 0; ev_d0[k] = 0; ev_d1[k] = 0; ev_rd[k] = 0;
            end
            last1     = 1'b1;
            next_free = cyc + 1;
            m_rdata   = 8'h00;
            m_conf    = 0;
        end else if (cyc + 4 < MAXC) begin
            eg0 = 0; eg1 = 0; w = 0;
            if (cyc >= next_free && (Req0 || Req1)) begin
                w = (Req0 && Req1) ? !last1 : Req1;
                eg0 = !w; eg1 = w;
            end
            if (ev_cmd[cyc]) begin
                if (ev_rw[cyc]) ref_mem[ev_a[cyc]] = ev_d[cyc];
                else begin
                    ev_rd[cyc + 2]  = 1;
                    ev_rdv[cyc + 2] = ref_mem[ev_a[cyc]];
                end
            end
            if (ev_rd[cyc]) m_rdata = ev_rdv[cyc];
            chk("gnt0", Gnt0, eg0);
            chk("gnt1", Gnt1, eg1);
            chk("done0", Done0, ev_d0[cyc]);
            chk("done1", Done1, ev_d1[cyc]);
            chk("rs_en", RS_Enable, ev_cmd[cyc]);
            chk("rs_rw", RS_RW, ev_cmd[cyc] && ev_rw[cyc]);
            chk("rs_addr", RS_Address, ev_cmd[cyc] ? ev_a[cyc] : 3'd0);
            chk("rs_din", RS_Data_in, ev_cmd[cyc] ? ev_d[cyc] : 8'd0);
            chk("rdata", Rdata, m_rdata);
`ifdef REGSET_ARB_STATS_EN
            chk("conflict_cnt", Conflict_cnt, m_conf);
            if (cyc >= next_free && Req0 && Req1 && m_conf < 255) m_conf++;
`endif
            if (log_en && Gnt0) glog.push_back(0);
            if (log_en && Gnt1) glog.push_back(1);
            if (eg0 || eg1) begin
                rw = w ? RW1 : RW0;
                a  = w ? Addr1 : Addr0;
                d  = w ? Wdata1 : Wdata0;
                ev_cmd[cyc + 1] = 1; ev_rw[cyc + 1] = rw;
                ev_a[cyc + 1] = a;   ev_d[cyc + 1] = d;
                if (rw) begin
                    if (w) ev_d1[cyc + 1] = 1; else ev_d0[cyc + 1] = 1;
                    next_free = cyc + 2;
                end else begin
                    if (w) ev_d1[cyc + 3] = 1; else ev_d0[cyc + 3] = 1;
                    next_free = cyc + 3;
                end
                last1 = w;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_txn(input bit w, input bit rw, input logic [2:0] a, input logic [7:0] d,
                          output int gcyc);
        bit got;
        got  = 0;
        gcyc = -1;
        if (w) begin RW1 = rw; Addr1 = a; Wdata1 = d; Req1 = 1; end
        else   begin RW0 = rw; Addr0 = a; Wdata0 = d; Req0 = 1; end
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((w && Gnt1) || (!w && Gnt0)) begin got = 1; gcyc = cyc; break; end
            tick();
        end
        chk(w ? "gnt1_wait" : "gnt0_wait", got, 1);
        tick();
        if (w) Req1 = 0; else Req0 = 0;
    endtask

    initial begin
        #30000;
        $display("FAIL watchdog: got timeout expected finish");
        total++;
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        int t, g;
        Reset = 1; Req0 = 0; Req1 = 0; RW0 = 0; RW1 = 0;
        Addr0 = '0; Addr1 = '0; Wdata0 = '0; Wdata1 = '0;
        tick(); tick();
        Reset = 0;
        #1;
        chk("post_rst_outputs", {Gnt0, Gnt1, Done0, Done1, RS_Enable, RS_RW}, 0);
        chk("post_rst_rs_fields", {RS_Address, RS_Data_in}, 0);
        chk("post_rst_rdata", Rdata, 0);
        tick(); tick();

        // Write 0x03 to register 2 from requester 0.
        do_txn(0, 1, 3'b010, 8'h03, t);
        #1;
        chk("wr_cmd_cycle", cyc, t + 1);
        chk("wr_rs_en", RS_Enable, 1);
        chk("wr_rs_rw", RS_RW, 1);
        chk("wr_rs_addr", RS_Address, 2);
        chk("wr_rs_din", RS_Data_in, 8'h03);
        chk("wr_done0", Done0, 1);

        // Read it back from requester 1; Done lands three cycles after the grant.
        do_txn(1, 0, 3'b010, 8'h00, g);
        chk("rd_gnt_cycle", g, t + 2);
        tick(); tick();
        #1;
        chk("rd_done_cycle", cyc, g + 3);
        chk("rd_done1", Done1, 1);
        chk("rd_done0_quiet", Done0, 0);
        chk("rd_rdata", Rdata, 8'h03);

        // Both requesters held: grants must alternate starting with 0.
        RW0 = 1; Addr0 = 3'd1; Wdata0 = 8'h11;
        RW1 = 1; Addr1 = 3'd4; Wdata1 = 8'h44;
        Req0 = 1; Req1 = 1; log_en = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (glog.size() >= 4) break;
        end
        Req0 = 0; Req1 = 0; log_en = 0;
        chk("rr_grant_count", glog.size(), 4);
        if (glog.size() >= 4) begin
            chk("rr_order0", glog[0], 0);
            chk("rr_order1", glog[1], 1);
            chk("rr_order2", glog[2], 0);
            chk("rr_order3", glog[3], 1);
        end
        tick(); tick();

        do_txn(1, 0, 3'd4, 8'h00, g);
        tick(); tick();
        #1;
        chk("rd4_done1", Done1, 1);
        chk("rd4_rdata", Rdata, 8'h44);

        // Top address / all-ones data, then a read aborted by reset in RWAIT.
        do_txn(0, 1, 3'd7, 8'hFF, g);
        do_txn(0, 0, 3'd7, 8'h00, g);
        tick();
        Reset = 1;
        tick();
        Reset = 0;
        RW0 = 1; Addr0 = 3'd0; Wdata0 = 8'h5A; Req0 = 1;
        RW1 = 1; Addr1 = 3'd3; Wdata1 = 8'hA5; Req1 = 1;
        #1;
        chk("abort_no_done0", Done0, 0);
        chk("abort_rs_en", RS_Enable, 0);
        chk("abort_rdata", Rdata, 0);
        chk("abort_gnt0", Gnt0, 1);
        chk("abort_gnt1", Gnt1, 0);
        tick();
        Req0 = 0; Req1 = 0;
        repeat (5) tick();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
